// File: rtl/population_dispatcher_if.sv
// Bundle of the dispatcher's memory, evaluator and controller signals.
// The master modport is the dispatcher; the slave modport is everything around it.
interface population_dispatcher_if #(
    parameter int DATA_WIDTH      = 4,
    parameter int LATTICE_LENGTH  = 11,
    parameter int SELF_FIT_LENGTH = 10,
    parameter int ADDR_WIDTH      = 6
);
    localparam int INDIVIDUAL_LENGTH = LATTICE_LENGTH * DATA_WIDTH;

    logic                         start_i;
    logic                         pop_rd_en_o;
    logic [ADDR_WIDTH-1:0]        pop_rd_addr_o;
    logic [INDIVIDUAL_LENGTH-1:0] pop_rd_data_i;
    logic                         wr_initial_o;
    logic [INDIVIDUAL_LENGTH-1:0] individual_vec_o;
    logic                         in_valid_o;
    logic                         fit_valid_i;
    logic [SELF_FIT_LENGTH-1:0]   fit_data_i;
    logic                         fit_wr_en_o;
    logic [ADDR_WIDTH-1:0]        fit_wr_addr_o;
    logic [SELF_FIT_LENGTH-1:0]   fit_wr_data_o;
    logic [SELF_FIT_LENGTH-1:0]   best_fit_o;
    logic [ADDR_WIDTH-1:0]        best_idx_o;
    logic                         busy_o;
    logic                         done_o;

    modport master (
        input  start_i, pop_rd_data_i, fit_valid_i, fit_data_i,
        output pop_rd_en_o, pop_rd_addr_o, wr_initial_o, individual_vec_o, in_valid_o,
               fit_wr_en_o, fit_wr_addr_o, fit_wr_data_o, best_fit_o, best_idx_o,
               busy_o, done_o
    );

    modport slave (
        output start_i, pop_rd_data_i, fit_valid_i, fit_data_i,
        input  pop_rd_en_o, pop_rd_addr_o, wr_initial_o, individual_vec_o, in_valid_o,
               fit_wr_en_o, fit_wr_addr_o, fit_wr_data_o, best_fit_o, best_idx_o,
               busy_o, done_o
    );
endinterface

// File: rtl/population_dispatcher.sv
// Runs one fitness-evaluation pass: streams every individual to the evaluator,
// stores returned energies in arrival order and tracks the minimum-energy individual.
module population_dispatcher #(
    parameter int NUM_PARTICLE_TYPE = 3,
    parameter int DATA_WIDTH        = 4,
    parameter int LATTICE_LENGTH    = 11,
    parameter int INDIVIDUAL_LENGTH = LATTICE_LENGTH * DATA_WIDTH,
    parameter int SELF_FIT_LENGTH   = 10,
    parameter int POP_SIZE          = 50,
    parameter int ADDR_WIDTH        = 6
) (
    input  logic                   clk_i,
    input  logic                   rst_n,
    population_dispatcher_if.master bus
);
    // Counters must be able to hold POP_SIZE itself, one past the last address.
    localparam int CNT_WIDTH = $clog2(POP_SIZE + 1);

    if (NUM_PARTICLE_TYPE < 1 || (2 ** ADDR_WIDTH) < POP_SIZE) begin : g_param_check
        $error("population_dispatcher: invalid NUM_PARTICLE_TYPE or ADDR_WIDTH too small");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e                       state_q, state_d;
    logic [CNT_WIDTH-1:0]         issue_cnt_q, issue_cnt_d;
    logic [CNT_WIDTH-1:0]         recv_cnt_q, recv_cnt_d;
    logic [SELF_FIT_LENGTH-1:0]   best_fit_q, best_fit_d;
    logic [ADDR_WIDTH-1:0]        best_idx_q, best_idx_d;
    logic                         rd_en_q;
    logic                         in_valid_q;
    logic [INDIVIDUAL_LENGTH-1:0] vec_q;

    logic                         pop_rd_en;
    logic [ADDR_WIDTH-1:0]        pop_rd_addr;
    logic                         wr_initial;
    logic                         accept;

    // NOTE: every variable gets a default before the case so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        best_fit_d  = best_fit_q;
        best_idx_d  = best_idx_q;
        pop_rd_en   = 1'b0;
        pop_rd_addr = '0;
        wr_initial  = 1'b0;
        accept      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start_i) state_d = S_INIT;
            end
            S_INIT: begin
                wr_initial  = 1'b1;
                issue_cnt_d = '0;
                recv_cnt_d  = '0;
                best_fit_d  = '1;
                best_idx_d  = '0;
                state_d     = S_STREAM;
            end
            S_STREAM: begin
                pop_rd_en   = 1'b1;
                pop_rd_addr = ADDR_WIDTH'(issue_cnt_q);
                issue_cnt_d = issue_cnt_q + 1'b1;
                if (issue_cnt_q == CNT_WIDTH'(POP_SIZE - 1)) state_d = S_DRAIN;
            end
            S_DRAIN: ;
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Results are only collected while a pass is in flight and not yet complete.
        if ((state_q == S_STREAM || state_q == S_DRAIN) && bus.fit_valid_i &&
            recv_cnt_q < CNT_WIDTH'(POP_SIZE)) begin
            accept     = 1'b1;
            recv_cnt_d = recv_cnt_q + 1'b1;
            if (bus.fit_data_i < best_fit_q) begin
                best_fit_d = bus.fit_data_i;
                best_idx_d = ADDR_WIDTH'(recv_cnt_q);
            end
        end

        if (state_q == S_DRAIN && recv_cnt_d == CNT_WIDTH'(POP_SIZE)) state_d = S_DONE;
    end

    // NOTE: state is updated with non-blocking assignments so all registers sample the same pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            best_fit_q  <= '1;
            best_idx_q  <= '0;
            rd_en_q     <= 1'b0;
            in_valid_q  <= 1'b0;
            vec_q       <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            best_fit_q  <= best_fit_d;
            best_idx_q  <= best_idx_d;
            rd_en_q     <= pop_rd_en;
            in_valid_q  <= rd_en_q;
            if (rd_en_q) vec_q <= bus.pop_rd_data_i;
        end
    end

    assign bus.pop_rd_en_o      = pop_rd_en;
    assign bus.pop_rd_addr_o    = pop_rd_addr;
    assign bus.wr_initial_o     = wr_initial;
    assign bus.individual_vec_o = vec_q;
    assign bus.in_valid_o       = in_valid_q;
    assign bus.fit_wr_en_o      = accept;
    assign bus.fit_wr_addr_o    = ADDR_WIDTH'(recv_cnt_q);
    assign bus.fit_wr_data_o    = bus.fit_data_i;
    assign bus.best_fit_o       = best_fit_q;
    assign bus.best_idx_o       = best_idx_q;
    assign bus.busy_o           = (state_q != S_IDLE);
    assign bus.done_o           = (state_q == S_DONE);
endmodule
